// File: rtl/bch_frame_ctrl.sv
// Framing controller ahead of a BCH encoder: passes K/BITS data words, then
// inserts (N-K)/BITS zero parity slots, through one output register.
module bch_frame_ctrl #(
    parameter int N    = 15,
    parameter int K    = 7,
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] in_data,
    input  logic            in_start,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BITS-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_first,
    output logic            out_last,
    output logic            data_phase,
    output logic            err
);

    localparam int NW = N / BITS;
    localparam int DW = K / BITS;
    localparam int PW = (N - K) / BITS;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [CW:0] DW_L  = (CW+1)'(DW);
    localparam logic [CW:0] TOT_L = (CW+1)'(DW + PW);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    typedef struct packed {
        logic [BITS-1:0] data;
        logic            first;
        logic            last;
        logic            phase;
    } oreg_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [CW:0]     cnt_inc;
    oreg_t           oreg, oreg_n;
    logic            ovld, ovld_n;
    logic            err_q, err_n;
    logic            load_ok, accept, data_load;

    assign out_data   = oreg.data;
    assign out_first  = oreg.first;
    assign out_last   = oreg.last;
    assign data_phase = oreg.phase;
    assign out_valid  = ovld;
    assign err        = err_q;

    // The register can take a new word when empty or draining this cycle.
    assign load_ok  = !ovld || out_ready;
    assign in_ready = (state != PARITY) && load_ok;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = {1'b0, cnt} + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            oreg  <= '0;
            ovld  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            oreg  <= oreg_n;
            ovld  <= ovld_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        oreg_n    = oreg;
        ovld_n    = ovld && !out_ready;
        err_n     = 1'b0;
        data_load = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_start) begin
                        data_load    = 1'b1;
                        oreg_n.first = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    // A stray start mid-codeword is flagged but not honoured.
                    data_load    = 1'b1;
                    oreg_n.first = 1'b0;
                    err_n        = in_start;
                end
            end
            PARITY: begin
                if (load_ok) begin
                    ovld_n       = 1'b1;
                    oreg_n.data  = '0;
                    oreg_n.first = 1'b0;
                    oreg_n.phase = 1'b0;
                    if (cnt_inc == TOT_L) begin
                        oreg_n.last = 1'b1;
                        cnt_n       = '0;
                        state_n     = IDLE;
                    end else begin
                        oreg_n.last = 1'b0;
                        cnt_n       = cnt_inc[CW-1:0];
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (data_load) begin
            ovld_n       = 1'b1;
            oreg_n.data  = in_data;
            oreg_n.phase = 1'b1;
            oreg_n.last  = 1'b0;
            if (cnt_inc == DW_L) begin
                // Without parity slots the final data word closes the codeword.
                if (PW == 0) begin
                    oreg_n.last = 1'b1;
                    cnt_n       = '0;
                    state_n     = IDLE;
                end else begin
                    cnt_n   = cnt_inc[CW-1:0];
                    state_n = PARITY;
                end
            end else begin
                cnt_n   = cnt_inc[CW-1:0];
                state_n = DATA;
            end
        end
    end

endmodule

// File: tb/tb_bch_frame_ctrl.sv
// Scoreboard bench: instance a is 15/7/1, instance b is 16/8/4.
module tb_bch_frame_ctrl;

    typedef struct packed {
        logic [3:0] d;
        logic       f;
        logic       l;
        logic       ph;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       a_data, a_start, a_valid, a_ready, a_odata, a_ovalid, a_ordy;
    logic       a_ofirst, a_olast, a_ophase, a_err;
    logic [3:0] b_data, b_odata;
    logic       b_start, b_valid, b_ready, b_ovalid, b_ordy;
    logic       b_ofirst, b_olast, b_ophase, b_err;

    bch_frame_ctrl #(.N(15), .K(7), .BITS(1)) u_a (
        .clk(clk), .reset(rst), .in_data(a_data), .in_start(a_start), .in_valid(a_valid),
        .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_ordy),
        .out_first(a_ofirst), .out_last(a_olast), .data_phase(a_ophase), .err(a_err));

    bch_frame_ctrl #(.N(16), .K(8), .BITS(4)) u_b (
        .clk(clk), .reset(rst), .in_data(b_data), .in_start(b_start), .in_valid(b_valid),
        .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_ordy),
        .out_first(b_ofirst), .out_last(b_olast), .data_phase(b_ophase), .err(b_err));

    int   errors = 0, checks = 0, cyc = 0;
    exp_t qa[$], qb[$];
    int   dw[2] = '{7, 2};
    int   pw[2] = '{8, 2};
    int   m_pos[2], m_err[2], nout[2], firstc[2], lastc[2], errs[2], rmode[2];
    logic       a_hold = 1'b0, b_hold = 1'b0;
    logic [6:0] a_held, b_held;

    always @(posedge clk) cyc++;

    // out_ready pattern per instance: 0 = always, 1 = toggle, 2 = random
    always @(posedge clk) begin
        #1;
        a_ordy = (rmode[0] == 0) ? 1'b1 : (rmode[0] == 1) ? ~a_ordy : 1'($urandom);
        b_ordy = (rmode[1] == 0) ? 1'b1 : (rmode[1] == 1) ? ~b_ordy : 1'($urandom);
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) a_hold = 1'b0;
        else begin
            if (a_err) errs[0]++;
            if (a_hold) begin
                checks++;
                if ({3'b0, a_odata, a_ofirst, a_olast, a_ophase} !== a_held) begin
                    errors++;
                    $display("FAIL a_stable got=%b want=%b", {3'b0, a_odata, a_ofirst, a_olast, a_ophase}, a_held);
                end
            end
            a_hold = a_ovalid && !a_ordy;
            a_held = {3'b0, a_odata, a_ofirst, a_olast, a_ophase};
            if (a_ovalid && a_ordy) begin
                nout[0]++; lastc[0] = cyc;
                if (nout[0] == 1) firstc[0] = cyc;
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_extra_word got=%b want=none", {3'b0, a_odata, a_ofirst, a_olast, a_ophase});
                end else begin
                    e = qa.pop_front();
                    if ({3'b0, a_odata, a_ofirst, a_olast, a_ophase} !== e) begin
                        errors++;
                        $display("FAIL a_word got=%b want=%b (d,first,last,phase)", {3'b0, a_odata, a_ofirst, a_olast, a_ophase}, e);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) b_hold = 1'b0;
        else begin
            if (b_err) errs[1]++;
            if (b_hold) begin
                checks++;
                if ({b_odata, b_ofirst, b_olast, b_ophase} !== b_held) begin
                    errors++;
                    $display("FAIL b_stable got=%b want=%b", {b_odata, b_ofirst, b_olast, b_ophase}, b_held);
                end
            end
            b_hold = b_ovalid && !b_ordy;
            b_held = {b_odata, b_ofirst, b_olast, b_ophase};
            if (b_ovalid && b_ordy) begin
                nout[1]++; lastc[1] = cyc;
                if (nout[1] == 1) firstc[1] = cyc;
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_extra_word got=%b want=none", {b_odata, b_ofirst, b_olast, b_ophase});
                end else begin
                    e = qb.pop_front();
                    if ({b_odata, b_ofirst, b_olast, b_ophase} !== e) begin
                        errors++;
                        $display("FAIL b_word got=%b want=%b (d,first,last,phase)", {b_odata, b_ofirst, b_olast, b_ophase}, e);
                    end
                end
            end
        end
    end

    task automatic push(input int i, input exp_t e);
        if (i == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send(input int i, input logic [3:0] d, input logic st, output int waited);
        logic rdy;
        exp_t e;
        if (i == 0) begin a_data = d[0]; a_start = st; a_valid = 1'b1; end
        else begin b_data = d; b_start = st; b_valid = 1'b1; end
        waited = 0;
        rdy = 1'b0;
        while (!rdy && waited <= 200) begin
            @(negedge clk);
            rdy = (i == 0) ? a_ready : b_ready;
            if (!rdy) waited++;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout inst=%0d got=not_ready want=ready", i);
        end else if (m_pos[i] == 0 && !st) begin
            m_err[i]++;
        end else begin
            if (m_pos[i] != 0 && st) m_err[i]++;
            e.d  = (i == 0) ? {3'b0, d[0]} : d;
            e.f  = (m_pos[i] == 0);
            e.ph = 1'b1;
            m_pos[i]++;
            e.l  = (m_pos[i] == dw[i]) && (pw[i] == 0);
            push(i, e);
            if (m_pos[i] == dw[i]) begin
                for (int p = 0; p < pw[i]; p++) begin
                    e.d = 4'd0; e.f = 1'b0; e.ph = 1'b0; e.l = (p == pw[i] - 1);
                    push(i, e);
                end
                m_pos[i] = 0;
            end
        end
        @(posedge clk); #1;
        if (i == 0) a_valid = 1'b0; else b_valid = 1'b0;
    endtask

    task automatic send_cw(input int i, input int extra, output int w0, output int wrest);
        int w;
        wrest = 0; w0 = 0;
        for (int k = 0; k < dw[i]; k++) begin
            send(i, 4'($urandom), (k == 0) || (k == extra), w);
            if (k == 0) w0 = w; else if (w > wrest) wrest = w;
        end
    endtask

    task automatic drain(input int i);
        int t = 0;
        while (((i == 0) ? (qa.size() != 0 || a_ovalid) : (qb.size() != 0 || b_ovalid)) && t < 300) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL drain_timeout inst=%0d got=%0d pending want=0", i, (i == 0) ? qa.size() : qb.size());
        end
        checks++;
        if (errs[i] !== m_err[i]) begin
            errors++;
            $display("FAIL err_count inst=%0d got=%0d want=%0d", i, errs[i], m_err[i]);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({a_ovalid, a_odata, a_ofirst, a_olast, a_ophase, a_err, a_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_a got=%b want=0000001", {a_ovalid, a_odata, a_ofirst, a_olast, a_ophase, a_err, a_ready});
        end
        checks++;
        if ({b_ovalid, b_odata, b_ofirst, b_olast, b_ophase, b_err, b_ready} !== 10'b0000000001) begin
            errors++;
            $display("FAIL reset_b got=%b want=0000000001", {b_ovalid, b_odata, b_ofirst, b_olast, b_ophase, b_err, b_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_stream;
        int w, w0, wr;
        rmode[0] = 0; nout[0] = 0;
        send(0, 4'd1, 1'b1, w);
        checks++;
        if ({a_ovalid, a_ofirst, a_ophase, a_odata} !== 4'b1111) begin
            errors++;
            $display("FAIL stream_latency got=%b want=1111", {a_ovalid, a_ofirst, a_ophase, a_odata});
        end
        for (int k = 1; k < 7; k++) send(0, 4'(k & 1), 1'b0, w);
        send_cw(0, -1, w0, wr);
        checks++;
        if (w0 !== 8) begin errors++; $display("FAIL stream_parity_stall got=%0d want=8", w0); end
        checks++;
        if (wr !== 0) begin errors++; $display("FAIL stream_throughput got=%0d want=0", wr); end
        drain(0);
        checks++;
        if (nout[0] !== 30 || lastc[0] - firstc[0] + 1 !== 30) begin
            errors++;
            $display("FAIL stream_count got=%0d span=%0d want=30", nout[0], lastc[0] - firstc[0] + 1);
        end
    endtask

    task automatic test_stall;
        int w0, wr;
        rmode[0] = 1; nout[0] = 0;
        send_cw(0, -1, w0, wr);
        send_cw(0, -1, w0, wr);
        drain(0);
        checks++;
        if (nout[0] !== 30) begin errors++; $display("FAIL stall_count got=%0d want=30", nout[0]); end
        rmode[0] = 0;
    endtask

    task automatic test_idle_err;
        int w;
        send(0, 4'd1, 1'b0, w);
        checks++;
        if ({a_err, a_ovalid} !== 2'b10) begin errors++; $display("FAIL idle_err got=%b want=10", {a_err, a_ovalid}); end
        @(posedge clk); #1;
        checks++;
        if ({a_err, a_ovalid} !== 2'b00) begin errors++; $display("FAIL idle_err_pulse got=%b want=00", {a_err, a_ovalid}); end
        drain(0);
    endtask

    task automatic test_mid_start;
        int w0, wr;
        nout[0] = 0;
        send_cw(0, 4, w0, wr);
        drain(0);
        checks++;
        if (nout[0] !== 15 || m_err[0] !== 2) begin
            errors++;
            $display("FAIL mid_start got=%0d/%0d want=15/2", nout[0], m_err[0]);
        end
    endtask

    task automatic test_mid_reset;
        int w, w0, wr;
        send(0, 4'd1, 1'b1, w);
        send(0, 4'd0, 1'b0, w);
        send(0, 4'd1, 1'b0, w);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_ovalid, a_odata, a_ofirst, a_olast, a_ophase, a_err, a_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL mid_reset_clear got=%b want=0000001", {a_ovalid, a_odata, a_ofirst, a_olast, a_ophase, a_err, a_ready});
        end
        qa.delete(); m_pos[0] = 0;
        @(posedge clk); #1;
        rst = 1'b0; nout[0] = 0;
        send_cw(0, -1, w0, wr);
        checks++;
        if (w0 !== 0) begin errors++; $display("FAIL reset_first_accept got=%0d want=0", w0); end
        drain(0);
        checks++;
        if (nout[0] !== 15) begin errors++; $display("FAIL mid_reset_count got=%0d want=15", nout[0]); end
    endtask

    task automatic test_back_to_back;
        int w0, wr;
        rmode[1] = 0; nout[1] = 0;
        for (int c = 0; c < 3; c++) begin
            send_cw(1, -1, w0, wr);
            checks++;
            if (w0 !== ((c == 0) ? 0 : 2)) begin
                errors++;
                $display("FAIL b_start_wait cw=%0d got=%0d want=%0d", c, w0, (c == 0) ? 0 : 2);
            end
        end
        drain(1);
        checks++;
        if (nout[1] !== 12 || lastc[1] - firstc[1] + 1 !== 12) begin
            errors++;
            $display("FAIL b_back_to_back got=%0d span=%0d want=12", nout[1], lastc[1] - firstc[1] + 1);
        end
        rmode[1] = 2;
        send_cw(1, -1, w0, wr);
        send_cw(1, -1, w0, wr);
        drain(1);
        checks++;
        if (nout[1] !== 20) begin errors++; $display("FAIL b_random_count got=%0d want=20", nout[1]); end
        rmode[1] = 0;
    endtask

    initial begin
        rst = 1'b1;
        a_data = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_ordy = 1'b1;
        b_data = 4'd0; b_start = 1'b0; b_valid = 1'b0; b_ordy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 0; m_err[i] = 0; nout[i] = 0; errs[i] = 0; rmode[i] = 0;
            firstc[i] = 0; lastc[i] = 0;
        end
        test_reset();
        test_stream();
        test_stall();
        test_idle_err();
        test_mid_start();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
